// File: rtl/bus_arbiter8_if.sv
// Handshake/bus bundle shared by the 8-way round-robin arbiter and its environment.
// The master modport is the arbiter side: it owns grant, select and the output beat.
interface bus_arbiter8_if #(
   parameter int WIDTH = 16
);
   logic [7:0]         req;
   logic [8*WIDTH-1:0] data_in;
   logic               out_ready;
   logic [WIDTH-1:0]   out;
   logic               out_valid;
   logic [7:0]         gnt;
   logic [2:0]         sel;
   logic               busy;

   modport master (
      input  req, data_in, out_ready,
      output out, out_valid, gnt, sel, busy
   );

   modport slave (
      output req, data_in, out_ready,
      input  out, out_valid, gnt, sel, busy
   );
endinterface

// File: rtl/bus_arbiter8.sv
// Round-robin arbiter/sequencer sharing one WIDTH-bit bus between 8 requesters,
// with bounded bursts and a valid/ready handshake toward a single sink.
//
//   state | meaning
//   IDLE  | no owner; gnt=0, out=0, waiting for any req
//   GRANT | lane sel owns the bus; beats flow while req[sel] && out_ready
module bus_arbiter8 #(
   parameter int WIDTH     = 16,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          reset,
   bus_arbiter8_if.master bus
);
   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

   state_t     state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic [2:0] sel_q, sel_d;
   logic [7:0] gnt_q, gnt_d;
   logic [7:0] cnt_q, cnt_d;

   logic       busy;
   logic       out_valid;
   logic       beat;
   logic       release_own;
   logic [3:0] pick;
   logic [2:0] search_base;

   // Returns {found, index}; scanning from lowest to highest priority lets the
   // highest-priority hit (index ptr) overwrite the others.
   function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
      logic [3:0] res;
      logic [2:0] idx;
      res = 4'b0;
      for (int k = 7; k >= 0; k--) begin
         idx = p + 3'(k);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   assign busy        = (state_q == GRANT);
   assign out_valid   = busy && bus.req[sel_q];
   assign beat        = out_valid && bus.out_ready;
   assign release_own = busy && (!bus.req[sel_q] || (beat && cnt_q == LAST_BEAT));
   assign search_base = busy ? sel_q + 3'd1 : ptr_q;
   assign pick        = rr_pick(bus.req, search_base);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      gnt_d   = gnt_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (pick[3]) begin
               state_d = GRANT;
               sel_d   = pick[2:0];
               gnt_d   = 8'b1 << pick[2:0];
               cnt_d   = 8'd0;
            end
         end
         GRANT: begin
            if (release_own) begin
               ptr_d = sel_q + 3'd1;
               cnt_d = 8'd0;
               if (pick[3]) begin
                  sel_d = pick[2:0];
                  gnt_d = 8'b1 << pick[2:0];
               end else begin
                  state_d = IDLE;
                  gnt_d   = 8'd0;
               end
            end else if (beat) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= 3'd0;
         sel_q   <= 3'd0;
         gnt_q   <= 8'd0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      bus.out = '0;
      if (busy) bus.out = bus.data_in[WIDTH*sel_q +: WIDTH];
   end

   assign bus.out_valid = out_valid;
   assign bus.gnt       = gnt_q;
   assign bus.sel       = sel_q;
   assign bus.busy      = busy;
endmodule

// File: tb/tb_bus_arbiter8.sv
// Directed bench for bus_arbiter8: stimulus pushes expected beats into a queue,
// a negedge monitor pops and compares each accepted beat.
module tb_bus_arbiter8;
   logic clk;
   logic reset;

   bus_arbiter8_if #(.WIDTH(16)) bus ();

   bus_arbiter8 #(.WIDTH(16), .MAX_BURST(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [2:0]  lane;
      logic [15:0] data;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] lanes[8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
      checks++;
      if (act !== req_v) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req_v, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_beats(input int lane, input int n);
      logic [2:0] l;
      l = lane[2:0];
      for (int k = 0; k < n; k++) exp_q.push_back('{l, lanes[lane]});
   endtask

   task automatic rst_seq();
      reset         = 1'b1;
      bus.req       = 8'h00;
      bus.out_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Monitor: every accepted beat must match the head of the expectation queue.
   always @(negedge clk) begin
      if (!reset) begin
         checks++;
         if ((bus.gnt !== (bus.busy ? (8'b1 << bus.sel) : 8'h00)) ||
             (bus.out_valid && !bus.busy)) begin
            errors++;
            $display("FAIL invariant gnt=%0h sel=%0d busy=%0b out_valid=%0b t=%0t",
                     bus.gnt, bus.sel, bus.busy, bus.out_valid, $time);
         end
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat sel=%0d out=%0h required=none t=%0t",
                        bus.sel, bus.out, $time);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (bus.sel !== e.lane || bus.out !== e.data || bus.gnt !== (8'b1 << e.lane)) begin
                  errors++;
                  $display("FAIL beat sel=%0d out=%0h gnt=%0h required sel=%0d out=%0h t=%0t",
                           bus.sel, bus.out, bus.gnt, e.lane, e.data, $time);
               end
            end
         end
      end
   end

   initial begin
      lanes[0] = 16'h0A00; lanes[1] = 16'h1A11; lanes[2] = 16'h2A22; lanes[3] = 16'hBEEF;
      lanes[4] = 16'h4A44; lanes[5] = 16'h5A55; lanes[6] = 16'h6A66; lanes[7] = 16'h7A77;
      for (int i = 0; i < 8; i++) bus.data_in[16*i +: 16] = lanes[i];
      reset         = 1'b1;
      bus.req       = 8'h00;
      bus.out_ready = 1'b0;

      // Reset with all requests up: nothing granted until reset is released.
      bus.req = 8'hFF;
      tick();
      tick();
      chk("rst_gnt",       32'(bus.gnt),       32'h0);
      chk("rst_busy",      32'(bus.busy),      32'h0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_out",       32'(bus.out),       32'h0);
      reset = 1'b0;
      tick();
      chk("first_sel", 32'(bus.sel), 32'd0);
      chk("first_gnt", 32'(bus.gnt), 32'h01);
      rst_seq();

      // Single requester: two back-to-back bursts on lane 3.
      bus.req       = 8'h08;
      bus.out_ready = 1'b1;
      expect_beats(3, 8);
      tick();
      chk("single_sel",       32'(bus.sel),       32'd3);
      chk("single_gnt",       32'(bus.gnt),       32'h08);
      chk("single_out",       32'(bus.out),       32'hBEEF);
      chk("single_out_valid", 32'(bus.out_valid), 32'h1);
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 4) begin
            chk("single_regrant_busy", 32'(bus.busy),      32'h1);
            chk("single_regrant_sel",  32'(bus.sel),       32'd3);
            chk("single_regrant_vld",  32'(bus.out_valid), 32'h1);
         end
      end
      bus.req = 8'h00;
      chk("single_q_empty", 32'(exp_q.size()), 32'd0);
      rst_seq();

      // Rotation between lanes 0 and 7, pointer wrapping 7 -> 0.
      bus.req       = 8'h81;
      bus.out_ready = 1'b1;
      expect_beats(0, 4);
      expect_beats(7, 4);
      expect_beats(0, 4);
      tick();
      chk("rot_sel0", 32'(bus.sel), 32'd0);
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (i == 4)  chk("rot_sel7",      32'(bus.sel), 32'd7);
         if (i == 8)  chk("rot_wrap_sel0", 32'(bus.sel), 32'd0);
         if (i == 12) chk("rot_sel7_again", 32'(bus.sel), 32'd7);
      end
      bus.out_ready = 1'b0;
      bus.req       = 8'h00;
      chk("rot_q_empty", 32'(exp_q.size()), 32'd0);
      rst_seq();

      // Stall lane 2 after one beat; exactly three more beats, then release to lane 5.
      bus.req       = 8'h24;
      bus.out_ready = 1'b1;
      expect_beats(2, 4);
      tick();
      tick();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("stall_sel", 32'(bus.sel),       32'd2);
         chk("stall_gnt", 32'(bus.gnt),       32'h04);
         chk("stall_out", 32'(bus.out),       32'(lanes[2]));
         chk("stall_vld", 32'(bus.out_valid), 32'h1);
      end
      bus.out_ready = 1'b1;
      tick();
      tick();
      chk("stall_still_2", 32'(bus.sel), 32'd2);
      tick();
      bus.out_ready = 1'b0;
      chk("stall_release_sel", 32'(bus.sel), 32'd5);
      chk("stall_release_gnt", 32'(bus.gnt), 32'h20);
      chk("stall_q_empty", 32'(exp_q.size()), 32'd0);
      rst_seq();

      // Owner lane 5 drops its request after two beats; lane 6 takes over.
      bus.req       = 8'h60;
      bus.out_ready = 1'b1;
      expect_beats(5, 2);
      tick();
      chk("drop_sel5", 32'(bus.sel), 32'd5);
      tick();
      tick();
      bus.req = 8'h40;
      #1;
      chk("drop_out_valid", 32'(bus.out_valid), 32'h0);
      chk("drop_still_gnt", 32'(bus.gnt),       32'h20);
      tick();
      bus.out_ready = 1'b0;
      chk("drop_gnt6", 32'(bus.gnt), 32'h40);
      chk("drop_sel6", 32'(bus.sel), 32'd6);
      chk("drop_q_empty", 32'(exp_q.size()), 32'd0);
      rst_seq();

      // Reset mid-burst on lane 4 (cnt=2); regrant restarts a full 4-beat burst.
      bus.req       = 8'h30;
      bus.out_ready = 1'b1;
      expect_beats(4, 2);
      tick();
      chk("mid_sel4", 32'(bus.sel), 32'd4);
      tick();
      tick();
      reset = 1'b1;
      tick();
      chk("mid_rst_gnt",  32'(bus.gnt),       32'h0);
      chk("mid_rst_busy", 32'(bus.busy),      32'h0);
      chk("mid_rst_out",  32'(bus.out),       32'h0);
      chk("mid_rst_vld",  32'(bus.out_valid), 32'h0);
      reset = 1'b0;
      expect_beats(4, 4);
      tick();
      chk("mid_regrant_sel", 32'(bus.sel), 32'd4);
      chk("mid_regrant_gnt", 32'(bus.gnt), 32'h10);
      for (int i = 1; i <= 4; i++) begin
         tick();
         if (i == 3) chk("mid_still_4", 32'(bus.sel), 32'd4);
      end
      bus.out_ready = 1'b0;
      chk("mid_release_sel", 32'(bus.sel), 32'd5);
      chk("mid_q_empty", 32'(exp_q.size()), 32'd0);
      rst_seq();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
